fdiv_s: RTL and testbench

- Iterative IEEE-754 single-precision divider: out = rs1 / rs2.
- Sits beside the fused multiply-add units in the float datapath.
- Multi-cycle, unlike the fixed-pipeline multiply and add units, so it uses a start/busy/done handshake.
- Restoring radix-2 mantissa divider: one quotient bit per cycle, then a normalise stage and a rounding stage.

---
 rtl/fp_pkg.sv | 81 ++++++++
 rtl/fp_round.sv | 49 ++++
 rtl/fdiv_s.sv | 164 ++++++++++++++++
 tb/tb_fdiv_s.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision float definitions for the float datapath units.
package fp_pkg;

    // Field widths and exponent bias
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = FRAC_W + 1;
    localparam int unsigned BIAS   = 127;

    // RISC-V frm encodings; 101..111 fall back to RNE
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [2:0] {
        StIdle,
        StSpecial,
        StDiv,
        StNorm,
        StRound
    } state_e;

    localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF    = 32'h7F80_0000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

    // fflags = {NV, DZ, OF, UF, NX}
    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;

    typedef struct packed {
        logic        hit;
        logic [31:0] res;
        logic [4:0]  flags;
    } special_t;

    // Special-case classification for a / b; denormals count as zero.
    function automatic special_t fdiv_special(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] canon);
        special_t sp;
        logic     sign;
        logic     a_zero, a_inf, a_nan, a_snan;
        logic     b_zero, b_inf, b_nan, b_snan;
        sign   = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        sp     = '0;
        if (a_nan || b_nan) begin
            sp.hit            = 1'b1;
            sp.res            = canon;
            sp.flags[FLAG_NV] = a_snan || b_snan;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            sp.hit            = 1'b1;
            sp.res            = canon;
            sp.flags[FLAG_NV] = 1'b1;
        end else if (b_zero && !a_inf) begin
            sp.hit            = 1'b1;
            sp.res            = {sign, POS_INF[30:0]};
            sp.flags[FLAG_DZ] = 1'b1;
        end else if (a_inf) begin
            sp.hit = 1'b1;
            sp.res = {sign, POS_INF[30:0]};
        end else if (a_zero || b_inf) begin
            sp.hit = 1'b1;
            sp.res = {sign, 31'd0};
        end
        return sp;
    endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational IEEE-754 single-precision rounder with overflow handling.
// Expects a normalised significand and a biased exponent >= 1.
module fp_round
    import fp_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  exp,
    input  logic [SIG_W-1:0]   sig,
    input  logic               guard,
    input  logic               round,
    input  logic               sticky,
    input  logic [2:0]         rm,
    output logic [31:0]        result,
    output logic               of,
    output logic               nx
);

    logic              inexact;
    logic              round_up;
    logic              keep_max;
    logic [SIG_W:0]    sum;
    logic signed [9:0] exp_r;
    logic [FRAC_W-1:0] frac;

    // Increment decision, significand add, carry into the exponent, overflow select
    always_comb begin
        inexact = guard | round | sticky;
        case (rm)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = inexact & sign;
            RM_RUP:  round_up = inexact & ~sign;
            RM_RMM:  round_up = guard;
            default: round_up = guard & (round | sticky | sig[0]);
        endcase
        sum   = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};
        exp_r = exp + $signed({9'd0, sum[SIG_W]});
        // On carry-out the significand is 1.000..0, so both slices give a zero fraction
        frac  = sum[SIG_W] ? sum[SIG_W-1:1] : sum[SIG_W-2:0];
        of    = (exp_r >= 10'sd255);
        keep_max = (rm == RM_RTZ) || ((rm == RM_RDN) && !sign) || ((rm == RM_RUP) && sign);
        if (of) begin
            result = keep_max ? {sign, MAX_FINITE[30:0]} : {sign, POS_INF[30:0]};
        end else begin
            result = {sign, exp_r[EXP_W-1:0], frac};
        end
        nx = inexact | of;
    end

endmodule

// File: rtl/fdiv_s.sv
// Iterative single-precision divider, out = rs1 / rs2, start/busy/done handshake.
// Restoring radix-2: one quotient bit per DIV cycle, then NORM and ROUND.
module fdiv_s #(
    parameter int unsigned QBITS     = 26,
    parameter logic [31:0] CANON_NAN = fp_pkg::CANON_NAN
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  rm,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic [4:0]  fflags
);

    import fp_pkg::*;

    localparam int unsigned CntW = $clog2(QBITS);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [SIG_W-1:0]  mb_q;
    logic [25:0]       rem_q;
    logic [25:0]       quo_q;
    logic              sticky_q;
    logic [2:0]        rm_q;
    logic              spec_q;
    logic [31:0]       spec_res_q;
    logic [4:0]        spec_flags_q;

    special_t          sp_in;
    logic [SIG_W-1:0]  ma, mb;
    logic              pre_shift;
    logic [25:0]       rem_init;
    logic signed [9:0] exp_init;
    logic              rem_ge;
    logic [25:0]       rem_sub;
    logic [25:0]       rem_next;
    logic [31:0]       rnd_res;
    logic              rnd_of, rnd_nx;
    logic [31:0]       div_res;
    logic [4:0]        div_flags;

    assign sp_in = fdiv_special(rs1, rs2, CANON_NAN);

    // Operand setup at accept: pre-shift so the first quotient bit is always 1
    always_comb begin
        ma        = {1'b1, rs1[22:0]};
        mb        = {1'b1, rs2[22:0]};
        pre_shift = (ma < mb);
        rem_init  = pre_shift ? {1'b0, ma, 1'b0} : {2'b00, ma};
        exp_init  = $signed({2'b00, rs1[30:23]}) - $signed({2'b00, rs2[30:23]})
                  + 10'sd127 - (pre_shift ? 10'sd1 : 10'sd0);
    end

    // One restoring step: conditional subtract, then shift the partial remainder
    always_comb begin
        rem_ge   = (rem_q >= {2'b00, mb_q});
        rem_sub  = rem_ge ? (rem_q - {2'b00, mb_q}) : rem_q;
        rem_next = rem_sub << 1;
    end

    fp_round u_round (
        .sign   (sign_q),
        .exp    (exp_q),
        .sig    (quo_q[25:2]),
        .guard  (quo_q[1]),
        .round  (quo_q[0]),
        .sticky (sticky_q),
        .rm     (rm_q),
        .result (rnd_res),
        .of     (rnd_of),
        .nx     (rnd_nx)
    );

    // Normal-path result: flush to signed zero when the exponent has no room
    always_comb begin
        div_res   = rnd_res;
        div_flags = '0;
        if (exp_q <= 10'sd0) begin
            div_res            = {sign_q, 31'd0};
            div_flags[FLAG_UF] = 1'b1;
            div_flags[FLAG_NX] = 1'b1;
        end else begin
            div_flags[FLAG_OF] = rnd_of;
            div_flags[FLAG_NX] = rnd_nx;
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            mb_q         <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            sticky_q     <= 1'b0;
            rm_q         <= '0;
            spec_q       <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            out          <= '0;
            fflags       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rm_q         <= rm;
                        sign_q       <= rs1[31] ^ rs2[31];
                        mb_q         <= mb;
                        rem_q        <= rem_init;
                        exp_q        <= exp_init;
                        quo_q        <= '0;
                        cnt_q        <= '0;
                        sticky_q     <= 1'b0;
                        spec_q       <= 1'b0;
                        spec_res_q   <= sp_in.res;
                        spec_flags_q <= sp_in.flags;
                        busy         <= 1'b1;
                        state_q      <= sp_in.hit ? StSpecial : StDiv;
                    end
                end
                StSpecial: begin
                    // Result was classified at accept; select it for the write-back
                    spec_q  <= 1'b1;
                    state_q <= StRound;
                end
                StDiv: begin
                    quo_q <= {quo_q[24:0], rem_ge};
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(QBITS - 1)) begin
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    // Quotient MSB is already 1, only the sticky bit is left to form
                    sticky_q <= (rem_q != 26'd0);
                    state_q  <= StRound;
                end
                StRound: begin
                    out     <= spec_q ? spec_res_q : div_res;
                    fflags  <= spec_q ? spec_flags_q : div_flags;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_s.sv
// Directed bench for fdiv_s with an integer-arithmetic reference model and
// a per-cycle scoreboard on busy/done/out/fflags.
module tb_fdiv_s;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] rs1, rs2;
    logic [2:0]  rm;
    logic        busy, done;
    logic [31:0] out;
    logic [4:0]  fflags;

    fdiv_s #(
        .QBITS     (26),
        .CANON_NAN (32'h7FC00000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .rs1    (rs1),
        .rs2    (rs2),
        .rm     (rm),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .fflags (fflags)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n = edge_n + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        int          done_edge;
    } exp_t;

    exp_t        sb[$];
    int          free_edge = 0;
    int          last_done = 0;
    logic [31:0] held_out = 32'd0;
    logic [4:0]  held_flags = 5'd0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, expv);
        end
    endtask

    // Reference: quotient from one wide integer division, then the rounding rules
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] r, output logic [31:0] res,
                                  output logic [4:0] fl, output int lat);
        logic   s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
        logic   g, rb, st, inx, up;
        int     ea, eb, e;
        longint fa, fb, ma, mb, num, q, rmd, sig;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        fl  = 5'b00000;
        lat = 2;
        res = 32'd0;
        if (a_nan || b_nan) begin
            res = 32'h7FC00000;
            if (a_snan || b_snan) fl = 5'b10000;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            res = 32'h7FC00000;
            fl  = 5'b10000;
        end else if (b_zero && !a_inf) begin
            res = {s, 31'h7F800000};
            fl  = 5'b01000;
        end else if (a_inf) begin
            res = {s, 31'h7F800000};
        end else if (a_zero || b_inf) begin
            res = {s, 31'd0};
        end else begin
            lat = 28;
            ma  = fa + 64'd8388608;
            mb  = fb + 64'd8388608;
            e   = ea - eb + 127;
            if (ma < mb) begin
                ma = ma * 2;
                e  = e - 1;
            end
            num = ma * 64'd33554432;
            q   = num / mb;
            rmd = num % mb;
            sig = q / 4;
            g   = q[1];
            rb  = q[0];
            st  = (rmd != 0);
            inx = g | rb | st;
            if (e <= 0) begin
                res = {s, 31'd0};
                fl  = 5'b00011;
            end else begin
                case (r)
                    3'd1:    up = 1'b0;
                    3'd2:    up = inx & s;
                    3'd3:    up = inx & ~s;
                    3'd4:    up = g;
                    default: up = g & (rb | st | sig[0]);
                endcase
                if (up) sig = sig + 1;
                if (sig == 64'd16777216) begin
                    sig = 64'd8388608;
                    e   = e + 1;
                end
                if (e >= 255) begin
                    fl = 5'b00101;
                    if (r == 3'd1 || (r == 3'd2 && !s) || (r == 3'd3 && s))
                        res = {s, 31'h7F7FFFFF};
                    else
                        res = {s, 31'h7F800000};
                end else begin
                    res = {s, e[7:0], sig[22:0]};
                    fl  = {4'b0000, inx};
                end
            end
        end
    endfunction

    task automatic pin(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] r, input logic [31:0] xres, input logic [4:0] xfl,
                       input int xlat);
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        model(a, b, r, res, fl, lat);
        chk({name, "_res"}, res, xres);
        chk({name, "_flags"}, {27'd0, fl}, {27'd0, xfl});
        chk({name, "_lat"}, lat, xlat);
    endtask

    // Scoreboard: every cycle, compare handshake and held result against expectation
    always @(negedge clk) begin : cmp
        logic exp_busy, exp_done;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (sb.size() > 0) begin
            exp_busy = (edge_n < sb[0].done_edge);
            exp_done = (edge_n == sb[0].done_edge);
        end
        if (exp_done) begin
            held_out   = sb[0].res;
            held_flags = sb[0].flags;
        end
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("out", out, held_out);
        chk("fflags", {27'd0, fflags}, {27'd0, held_flags});
        if (exp_done) void'(sb.pop_front());
    end

    // Drive start for one edge from the current (post-negedge) time
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        exp_t        x;
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        start = 1'b1;
        rs1   = a;
        rs2   = b;
        rm    = r;
        if (edge_n + 1 >= free_edge) begin
            model(a, b, r, res, fl, lat);
            x.res       = res;
            x.flags     = fl;
            x.done_edge = edge_n + 1 + lat;
            sb.push_back(x);
            last_done = x.done_edge;
            free_edge = x.done_edge + 1;
        end
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        @(negedge clk);
        #1;
        drive_start(a, b, r);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        issue(a, b, r);
        wait_idle();
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        rs1    = 32'd0;
        rs2    = 32'd0;
        rm     = 3'd0;

        // Hand-computed anchors for the model
        pin("six_by_two", 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 28);
        pin("third_rne", 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'b00001, 28);
        pin("third_rtz", 32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00001, 28);
        pin("neg_by_zero", 32'hBF800000, 32'h00000000, 3'd0, 32'hFF800000, 5'b01000, 2);
        pin("zero_zero", 32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000, 2);
        pin("inf_inf", 32'h7F800000, 32'h7F800000, 3'd0, 32'h7FC00000, 5'b10000, 2);
        pin("ovf_rne", 32'h7F000000, 32'h3E800000, 3'd0, 32'h7F800000, 5'b00101, 28);
        pin("ovf_rtz", 32'h7F000000, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 5'b00101, 28);
        pin("unf", 32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 5'b00011, 28);
        pin("neg_third_rdn", 32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'b00001, 28);

        #1 resetn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        resetn    = 1'b0;
        free_edge = edge_n + 1;

        // Test-plan vectors
        run(32'h40C00000, 32'h40000000, 3'd0);
        run(32'h3F800000, 32'h40400000, 3'd0);
        run(32'h3F800000, 32'h40400000, 3'd1);
        run(32'hBF800000, 32'h00000000, 3'd0);
        run(32'h00000000, 32'h00000000, 3'd0);
        run(32'h7F800000, 32'h7F800000, 3'd0);
        run(32'h7F000000, 32'h3E800000, 3'd0);
        run(32'h7F000000, 32'h3E800000, 3'd1);
        run(32'h00800000, 32'h40000000, 3'd0);

        // Further rounding modes, NaNs, infinities and denormal flush
        run(32'hBF800000, 32'h40400000, 3'd2);
        run(32'hBF800000, 32'h40400000, 3'd3);
        run(32'h3F800000, 32'h40400000, 3'd4);
        run(32'h3F800000, 32'h40400000, 3'd6);
        run(32'h7F800001, 32'h3F800000, 3'd0);
        run(32'h3F800000, 32'h7FC00001, 3'd0);
        run(32'hFF800000, 32'h00000000, 3'd0);
        run(32'h40000000, 32'hFF800000, 3'd0);
        run(32'h00000001, 32'h3F800000, 3'd0);
        run(32'h40000000, 32'h00400000, 3'd0);
        run(32'h7F000000, 32'h3E800000, 3'd2);
        run(32'hFF000000, 32'h3E800000, 3'd3);
        run(32'h3F7FFFFF, 32'h3F000001, 3'd3);
        run(32'h3FFFFFFF, 32'h3F800001, 3'd0);
        run(32'h42F6E979, 32'hC1200000, 3'd4);

        // start while busy is dropped; first result must stand
        issue(32'h40C00000, 32'h40000000, 3'd0);
        repeat (5) @(negedge clk);
        #1;
        drive_start(32'h3F800000, 32'h40400000, 3'd0);
        wait_idle();

        // start in the done cycle is accepted
        issue(32'h3F800000, 32'h40400000, 3'd0);
        for (int i = 0; i < 60 && edge_n != last_done; i++) begin
            @(negedge clk);
            #1;
        end
        drive_start(32'h40C00000, 32'h40000000, 3'd0);
        wait_idle();

        // Reset part-way through DIV aborts with no done
        issue(32'h3F800000, 32'h40400000, 3'd1);
        repeat (10) @(negedge clk);
        #1;
        resetn     = 1'b1;
        sb.delete();
        held_out   = 32'd0;
        held_flags = 5'd0;
        free_edge  = 0;
        @(negedge clk);
        #1;
        resetn    = 1'b0;
        free_edge = edge_n + 1;
        repeat (3) @(negedge clk);
        run(32'h7F000000, 32'h3E800000, 3'd1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
